// File: rtl/bitcell_array_ctrl.sv
// rtl/bitcell_array_ctrl.sv - round-robin two-port access sequencer for a NAND-latch bitcell array
`timescale 1ns/1ps
module bitcell_array_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic [WIDTH-1:0]     wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [WIDTH-1:0]     rdata0,
  output logic [WIDTH-1:0]     rdata1,
  output logic [(2**AW)-1:0]   cell_sel,
  output logic                 cell_we,
  output logic [WIDTH-1:0]     cell_wdata,
  input  logic [WIDTH-1:0]     cell_rdata,
  output logic                 busy
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {IDLE, SEL, OP, ACK} state_t;

  state_t           state;
  logic             last_grant;
  logic             gnt;
  logic             lat_we;
  logic             win;
  logic [AW-1:0]    win_addr;
  logic [DEPTH-1:0] win_onehot;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    win        = (req0 && req1) ? ~last_grant : req1;
    win_addr   = win ? addr1 : addr0;
    win_onehot = DEPTH'(1) << win_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt        <= 1'b0;
      lat_we     <= 1'b0;
      cell_sel   <= '0;
      cell_we    <= 1'b0;
      cell_wdata <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt        <= win;
            last_grant <= win;
            lat_we     <= win ? we1 : we0;
            cell_sel   <= win_onehot;
            cell_wdata <= win ? wdata1 : wdata0;
            busy       <= 1'b1;
            state      <= SEL;
          end
        end
        SEL: begin
          cell_we <= lat_we;
          state   <= OP;
        end
        OP: begin
          // Array word has been selected for a full cycle, so cell_rdata is settled here.
          if (!lat_we) begin
            if (gnt) rdata1 <= cell_rdata;
            else     rdata0 <= cell_rdata;
          end
          if (gnt) ack1 <= 1'b1;
          else     ack0 <= 1'b1;
          cell_sel   <= '0;
          cell_we    <= 1'b0;
          cell_wdata <= '0;
          state      <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bitcell_array_ctrl.md
# bitcell_array_ctrl

Two-port access controller for a NAND-latch bitcell memory array. It arbitrates round-robin between two requesters and sequences each granted access through a fixed select → operate → acknowledge cycle. It drives the array's one-hot cell select, write-enable and write data, and captures read data. It sits between the bitcell array and the logic blocks that share that array.

## Interface
- `WIDTH`, default 8: data bits per word.
- `AW`, default 4: address bits. The array depth is 2**AW, so every address is in range.
- `clk` in 1: the single clock. All state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0`, `req1` in 1: access request from requester 0 / 1.
- `we0`, `we1` in 1: 1 = write, 0 = read.
- `addr0`, `addr1` in AW: word address.
- `wdata0`, `wdata1` in WIDTH: write data.
- `ack0`, `ack1` out 1: one-cycle completion pulse.
- `rdata0`, `rdata1` out WIDTH: read data, one register per port.
- `cell_sel` out 2**AW: one-hot word select to the array.
- `cell_we` out 1: write strobe to the array.
- `cell_wdata` out WIDTH: data to the array.
- `cell_rdata` in WIDTH: data from the selected array word.
- `busy` out 1: high while `state != IDLE`.

## Operation
- **States:** IDLE, SEL, OP, ACK.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - If any request is present, pick a winner, latch that requester's `we`, `addr` and `wdata` into internal registers, record the winner in `last_grant`, and go to SEL.
- **Arbitration:**
  - One requester: it wins.
  - Both requesting: the port other than `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- **SEL:**
  - `cell_sel` = one-hot of the latched address.
  - `cell_wdata` = latched write data.
  - `cell_we` = 0.
  - Next state: OP.
- **OP:**
  - `cell_sel` and `cell_wdata` are held.
  - `cell_we` = latched `we`.
  - On a read, `cell_rdata` is sampled into the granted port's `rdata` register at the OP→ACK edge.
  - Next state: ACK.
- **ACK:**
  - Granted `ack` = 1 for exactly one cycle.
  - `cell_sel` = 0 and `cell_we` = 0.
  - Next state: IDLE.
- **Outputs outside the windows above:** `cell_sel` = 0, `cell_we` = 0, `cell_wdata` = 0.
- **Read data ports:**
  - `rdata0` changes only on a port-0 read completion; `rdata1` likewise for port 1.
  - Each holds its value indefinitely otherwise.
  - Writes never modify `rdata`.
- **Requester rules:**
  - Hold `req`, `we`, `addr` and `wdata` stable from assertion until `ack` is seen.
  - Drop `req` on the edge that ends the `ack` cycle.
  - `req` still high in the following IDLE cycle is a new transaction.
  - Request fields are sampled only in IDLE. Changes during SEL, OP or ACK are ignored.
- **The losing requester** keeps `req` high. It is served in the next IDLE cycle.
- **Reset (`rst_n` low), at any time including mid-access:**
  - `state` = IDLE, `last_grant` = 1.
  - `cell_sel` = 0, `cell_we` = 0, `cell_wdata` = 0.
  - `ack0` = `ack1` = 0, `rdata0` = `rdata1` = 0, `busy` = 0.
  - An interrupted access produces no `ack`. Array contents after an aborted write are undefined.

## Timing
- `req` high in IDLE at cycle N gives:
  - SEL at N+1, OP at N+2, ACK at N+3, IDLE at N+4.
- Access latency is 3 cycles from the request sample to `ack`.
- Throughput is one access per 4 cycles, with back-to-back grants when requests are pending.
- `cell_sel` is high for exactly 2 cycles (SEL, OP). `cell_we` is high for at most 1 cycle (OP), inside the select window.
- The array must present valid `cell_rdata` by the end of OP, one cycle after select.
- `rdata` is valid in the `ack` cycle and after it.
- All outputs are registered or decoded from registered state. There is no combinational path from `req*` to any output.

## Test plan
- **Reset:** assert `rst_n` = 0 with `req0` = `req1` = 1. All outputs are 0, `busy` = 0. After release, port 0 is granted first.
- **Write then read:**
  - Port 0 writes `0xA5` to addr 5. `cell_sel` = `0x0020` at N+1..N+2, `cell_we` = 1 only at N+2, `ack0` at N+3.
  - Then port 0 reads addr 5 against the array model. `rdata0` = `0xA5` at `ack0`.
- **Contention:**
  - `req0` and `req1` rise together and are held. Grants go 0, 1, 0, 1, with acks at cycles 3, 7, 11, 15.
  - `ack0` and `ack1` are never high together.
- **Single hog:**
  - `req1` stays high continuously with new addresses and `req0` stays low. `ack1` pulses every 4 cycles and `busy` falls for one IDLE cycle between accesses.
  - Raising `req0` gets it served within 4 cycles of the next IDLE.
- **Reset mid-write:**
  - `rst_n` drops during OP of a port-1 write. `cell_we` and `cell_sel` go 0 immediately and no `ack1` follows.
  - After release with both requests pending, port 0 is granted.
- **Port isolation:**
  - Port 1 reads addr 3 (`0x3C`) while `rdata0` holds `0xA5`. `rdata0` stays `0xA5` and `rdata1` = `0x3C`.
  - A port-0 write leaves `rdata0` unchanged.
